// File: rtl/uart_v2_rx_pkg.sv
// Shared definitions for the uart_v2 receive path: frame geometry and FSM state codes.
package uart_v2_rx_pkg;

    localparam int SAMPLES_PER_BIT = 4;
    localparam int DATA_BITS       = 8;

    // Phase counts ticks inside a bit; the start bit is judged at its centre, two ticks in.
    localparam logic [1:0] START_CENTRE = 2'd1;
    localparam logic [1:0] BIT_CENTRE   = 2'(SAMPLES_PER_BIT - 1);
    localparam logic [2:0] LAST_BIT     = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_ARM,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_sample_tick.sv
// Free-running sysclk divider producing a one-cycle oversample tick every CLKS_PER_SAMPLE cycles.
module uart_sample_tick #(
    parameter int CLKS_PER_SAMPLE = 109
) (
    input  logic sysclk,
    input  logic sysreset,
    output logic tick
);

    localparam int CW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_SAMPLE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/uart_v2_rx.sv
// 8N1 LSB-first UART receiver, 4x oversampled, with a single-byte holding register for the MCU.
module uart_v2_rx
    import uart_v2_rx_pkg::*;
#(
    parameter int CLKS_PER_SAMPLE = 109,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       sysclk,
    input  logic       sysreset,
    input  logic       rx_line,
    input  logic       rx_ack,
    output logic [7:0] parallel_out,
    output logic       rx_valid,
    output logic       overrun_err,
    output logic       framing_err
);

    logic tick;

    uart_sample_tick #(
        .CLKS_PER_SAMPLE(CLKS_PER_SAMPLE)
    ) u_sample_tick (
        .sysclk  (sysclk),
        .sysreset(sysreset),
        .tick    (tick)
    );

    // Synchronizer resets to idle-high so a reset never looks like a start edge.
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rx_line};
        end
    end

    assign s = sync[SYNC_STAGES-1];

    rx_state_t  state, state_n;
    logic [1:0] phase, phase_n;
    logic [2:0] bit_idx, bit_n;
    logic [7:0] shreg, shreg_n;
    logic       complete;

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state   <= ST_ARM;
            phase   <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            bit_idx <= bit_n;
        end
    end

    always_ff @(posedge sysclk) begin
        shreg <= shreg_n;
    end

    always_comb begin
        state_n  = state;
        phase_n  = phase;
        bit_n    = bit_idx;
        shreg_n  = shreg;
        complete = 1'b0;
        if (tick) begin
            case (state)
                ST_ARM: begin
                    if (s) state_n = ST_IDLE;
                end
                ST_IDLE: begin
                    if (!s) begin
                        state_n = ST_START;
                        phase_n = '0;
                    end
                end
                ST_START: begin
                    if (phase == START_CENTRE) begin
                        state_n = s ? ST_IDLE : ST_DATA;
                        phase_n = '0;
                        bit_n   = '0;
                    end else begin
                        phase_n = phase + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (phase == BIT_CENTRE) begin
                        shreg_n = {s, shreg[7:1]};
                        phase_n = '0;
                        bit_n   = bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) state_n = ST_STOP;
                    end else begin
                        phase_n = phase + 1'b1;
                    end
                end
                ST_STOP: begin
                    // A low stop bit parks in BREAK so a held-low line flags only once.
                    if (phase == BIT_CENTRE) begin
                        complete = 1'b1;
                        state_n  = s ? ST_IDLE : ST_BREAK;
                        phase_n  = '0;
                    end else begin
                        phase_n = phase + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (s) state_n = ST_IDLE;
                end
                default: state_n = ST_ARM;
            endcase
        end
    end

    // An ack coinciding with a completion retires the old byte and admits the new one.
    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            parallel_out <= '0;
            rx_valid     <= 1'b0;
            overrun_err  <= 1'b0;
            framing_err  <= 1'b0;
        end else if (complete) begin
            if (!rx_valid || rx_ack) begin
                parallel_out <= shreg;
                rx_valid     <= 1'b1;
                framing_err  <= !s;
                overrun_err  <= 1'b0;
            end else begin
                overrun_err <= 1'b1;
            end
        end else if (rx_ack) begin
            rx_valid    <= 1'b0;
            overrun_err <= 1'b0;
            framing_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_v2_rx.sv
// Bench for uart_v2_rx: directed scenarios plus random frames, checked against a sample-point model.
module tb_uart_v2_rx;

    localparam int CPS      = 4;
    localparam int BIT_CLKS = 16;

    logic       sysclk   = 1'b0;
    logic       sysreset = 1'b1;
    logic       rx_line  = 1'b1;
    logic       rx_ack   = 1'b0;
    logic [7:0] parallel_out;
    logic       rx_valid;
    logic       overrun_err;
    logic       framing_err;

    int n_cmp = 0;
    int n_err = 0;

    uart_v2_rx #(
        .CLKS_PER_SAMPLE(CPS),
        .SYNC_STAGES    (2)
    ) dut (
        .sysclk      (sysclk),
        .sysreset    (sysreset),
        .rx_line     (rx_line),
        .rx_ack      (rx_ack),
        .parallel_out(parallel_out),
        .rx_valid    (rx_valid),
        .overrun_err (overrun_err),
        .framing_err (framing_err)
    );

    always #5 sysclk = ~sysclk;

    // Reference: sample points measured in ticks from the first low tick k
    // (start k+2, data n at k+6+4n, stop k+38); line seen two edges late.
    typedef enum int {M_WAIT, M_IDLE, M_FRAME} mmode_t;

    mmode_t     m_mode = M_WAIT;
    int         m_cyc  = 0;
    int         m_k    = 0;
    int         m_tno;
    int         m_t;
    logic       m_l1   = 1'b1;
    logic       m_l2   = 1'b1;
    logic [7:0] m_bits = 8'h00;
    logic [7:0] m_data = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ovr   = 1'b0;
    logic       m_fer   = 1'b0;
    logic       m_tick;
    logic       m_cmpl_now;

    assign m_tno      = m_cyc / CPS;
    assign m_t        = m_tno - m_k;
    assign m_tick     = (m_cyc % CPS) == (CPS - 1);
    assign m_cmpl_now = m_tick && (m_mode == M_FRAME) && (m_t == 38);

    always @(posedge sysclk) begin
        if (sysreset) begin
            m_cyc   <= 0;
            m_mode  <= M_WAIT;
            m_l1    <= 1'b1;
            m_l2    <= 1'b1;
            m_data  <= 8'h00;
            m_valid <= 1'b0;
            m_ovr   <= 1'b0;
            m_fer   <= 1'b0;
        end else begin
            m_cyc <= m_cyc + 1;
            m_l1  <= rx_line;
            m_l2  <= m_l1;
            if (m_cmpl_now) begin
                if (!m_valid || rx_ack) begin
                    m_data  <= m_bits;
                    m_valid <= 1'b1;
                    m_fer   <= !m_l2;
                    m_ovr   <= 1'b0;
                end else begin
                    m_ovr <= 1'b1;
                end
            end else if (rx_ack) begin
                m_valid <= 1'b0;
                m_ovr   <= 1'b0;
                m_fer   <= 1'b0;
            end
            if (m_tick) begin
                case (m_mode)
                    M_WAIT:  if (m_l2) m_mode <= M_IDLE;
                    M_IDLE:  if (!m_l2) begin m_mode <= M_FRAME; m_k <= m_tno; end
                    default: begin
                        if (m_t == 2 && m_l2) m_mode <= M_IDLE;
                        if (m_t >= 6 && m_t <= 34 && ((m_t - 6) % 4) == 0)
                            m_bits[3'((m_t - 6) / 4)] <= m_l2;
                        if (m_t == 38) m_mode <= m_l2 ? M_IDLE : M_WAIT;
                    end
                endcase
            end
        end
    end

    function automatic logic [15:0] dut_vec();
        return {5'd0, parallel_out, rx_valid, overrun_err, framing_err};
    endfunction

    function automatic logic [15:0] exp_vec(input logic [7:0] d, input logic v, input logic o, input logic f);
        return {5'd0, d, v, o, f};
    endfunction

    // Vectors are {data, valid, overrun, framing}.
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%03h expected 0x%03h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge sysclk);
        chk("track", dut_vec(), exp_vec(m_data, m_valid, m_ovr, m_fer));
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic drive_bit(input logic b);
        rx_line = b;
        repeat (BIT_CLKS) step();
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        step();
        rx_ack = 1'b0;
    endtask

    // rst_bit >= 0 pulses sysreset in the middle of that data bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int rst_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_bit) begin
                rx_line = d[i];
                repeat (8) step();
                sysreset = 1'b1;
                step();
                sysreset = 1'b0;
                repeat (7) step();
            end else begin
                drive_bit(d[i]);
            end
        end
        drive_bit(stop);
    endtask

    logic       ack_hit;
    logic [7:0] rnd_d;
    logic       rnd_stop;

    initial begin
        repeat (3) @(negedge sysclk);
        chk("reset", dut_vec(), exp_vec(8'h00, 1'b0, 1'b0, 1'b0));
        sysreset = 1'b0;
        idle(40);
        chk("idle high", dut_vec(), exp_vec(8'h00, 1'b0, 1'b0, 1'b0));

        // Plain frame
        send_frame(8'hA5, 1'b1, -1);
        idle(4);
        chk("t1 A5", dut_vec(), exp_vec(8'hA5, 1'b1, 1'b0, 1'b0));

        // Overrun
        ack_pulse();
        send_frame(8'h3C, 1'b1, -1);
        idle(2);
        send_frame(8'hC3, 1'b1, -1);
        idle(4);
        chk("t2 overrun", dut_vec(), exp_vec(8'h3C, 1'b1, 1'b1, 1'b0));
        ack_pulse();
        chk("t2 ack clears", dut_vec(), exp_vec(8'h3C, 1'b0, 1'b0, 1'b0));

        // Framing error and break
        send_frame(8'h55, 1'b0, -1);
        chk("t3 framing", dut_vec(), exp_vec(8'h55, 1'b1, 1'b0, 1'b1));
        idle(40 * BIT_CLKS);
        chk("t3 break once", dut_vec(), exp_vec(8'h55, 1'b1, 1'b0, 1'b1));
        ack_pulse();
        rx_line = 1'b1;
        idle(32);
        send_frame(8'h01, 1'b1, -1);
        idle(4);
        chk("t3 recover", dut_vec(), exp_vec(8'h01, 1'b1, 1'b0, 1'b0));

        // Glitch rejection
        ack_pulse();
        rx_line = 1'b0;
        idle(CPS);
        rx_line = 1'b1;
        idle(BIT_CLKS);
        chk("t4 glitch", dut_vec(), exp_vec(8'h01, 1'b0, 1'b0, 1'b0));
        send_frame(8'h80, 1'b1, -1);
        idle(4);
        chk("t4 80", dut_vec(), exp_vec(8'h80, 1'b1, 1'b0, 1'b0));

        // Ack coinciding with completion
        ack_pulse();
        send_frame(8'h11, 1'b1, -1);
        idle(4);
        chk("t5 hold 11", dut_vec(), exp_vec(8'h11, 1'b1, 1'b0, 1'b0));
        ack_hit = 1'b0;
        fork
            send_frame(8'h7E, 1'b1, -1);
            begin
                repeat (200) begin
                    @(negedge sysclk);
                    if (m_cmpl_now && !ack_hit) begin
                        rx_ack  = 1'b1;
                        ack_hit = 1'b1;
                    end else begin
                        rx_ack = 1'b0;
                    end
                end
            end
        join
        chk("t5 ack window", {15'd0, ack_hit}, 16'd1);
        idle(2);
        chk("t5 7E", dut_vec(), exp_vec(8'h7E, 1'b1, 1'b0, 1'b0));

        // Reset mid-frame
        send_frame(8'hFF, 1'b1, 3);
        idle(8);
        chk("t6 reset FF", dut_vec(), exp_vec(8'h00, 1'b0, 1'b0, 1'b0));
        send_frame(8'h42, 1'b1, -1);
        idle(4);
        chk("t6 42", dut_vec(), exp_vec(8'h42, 1'b1, 1'b0, 1'b0));
        send_frame(8'h00, 1'b1, 3);
        idle(8);
        chk("t6 reset low line", dut_vec(), exp_vec(8'h00, 1'b0, 1'b0, 1'b0));
        send_frame(8'h9D, 1'b1, -1);
        idle(4);
        chk("t6 9D", dut_vec(), exp_vec(8'h9D, 1'b1, 1'b0, 1'b0));

        // Random frames, gaps, stop bits and acks
        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 1) == 1) ack_pulse();
            rnd_d    = 8'($urandom_range(0, 255));
            rnd_stop = ($urandom_range(0, 3) != 0);
            send_frame(rnd_d, rnd_stop, -1);
            rx_line = 1'b1;
            idle(int'($urandom_range(0, 20)));
        end
        idle(BIT_CLKS);
        ack_pulse();
        send_frame(8'hE7, 1'b1, -1);
        idle(4);
        chk("rand tail E7", dut_vec(), exp_vec(8'hE7, 1'b1, 1'b0, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
